// File: rtl/reg_writeback.sv
// Writeback sequencer: takes one retiring instruction at a time, waits for load
// data, aligns and extends it, and drives the single register-file write port.
module reg_writeback #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_valid_i,
  output logic        wb_ready_o,
  input  logic [1:0]  wb_sel_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_alu_i,
  input  logic [31:0] wb_pc_i,
  input  logic [2:0]  wb_funct3_i,
  input  logic [1:0]  wb_byte_off_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wdata_o,
  output logic        fwd_valid_o,
  output logic        load_pending_o,
  output logic [4:0]  pending_rd_o,
  output logic        err_o
);

  localparam int CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_WRITE     = 2'd2
  } state_t;

  // Returns {bad_funct3, extended_data}; unsupported load types yield zero data.
  function automatic logic [32:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [32:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {1'b0, {24{b[7]}}, b};
      3'b100:  r = {1'b0, 24'h000000, b};
      3'b001:  r = {1'b0, {16{h[15]}}, h};
      3'b101:  r = {1'b0, 16'h0000, h};
      3'b010:  r = {1'b0, rdata};
      default: r = {1'b1, 32'h00000000};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             accept_s;
  logic [32:0]      ext_s;

  assign wb_ready_o     = (state_q != ST_WAIT_LOAD);
  assign accept_s       = wb_valid_i & wb_ready_o;
  assign ext_s          = load_extend(funct3_q, off_q, dmem_rdata_i);

  assign rf_we_o        = (state_q == ST_WRITE) & (rd_q != 5'd0);
  assign fwd_valid_o    = rf_we_o;
  assign rf_rd_o        = rd_q;
  assign rf_wdata_o     = data_q;
  assign load_pending_o = (state_q == ST_WAIT_LOAD);
  assign pending_rd_o   = rd_q;
  assign err_o          = err_q;

  // Next-state and datapath register update.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        // A response with no load outstanding is a protocol error.
        if (dmem_rvalid_i) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (accept_s) begin
          case (wb_sel_i)
            2'b01: begin
              rd_d    = wb_rd_i;
              data_d  = wb_alu_i;
              state_d = ST_WRITE;
            end
            2'b11: begin
              rd_d    = wb_rd_i;
              data_d  = wb_pc_i + 32'd4;
              state_d = ST_WRITE;
            end
            2'b10: begin
              rd_d     = wb_rd_i;
              funct3_d = wb_funct3_i;
              off_d    = wb_byte_off_i;
              cnt_d    = {CNT_W{1'b0}};
              state_d  = ST_WAIT_LOAD;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOAD: begin
        if (dmem_rvalid_i) begin
          data_d  = ext_s[31:0];
          err_d   = err_q | ext_s[32];
          state_d = ST_WRITE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_q     <= 5'd0;
      data_q   <= 32'd0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      cnt_q    <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed-vector bench for reg_writeback with hand-computed expectations.
module tb_reg_writeback;

  logic        clock;
  logic        reset_n;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [1:0]  wb_sel_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_alu_i;
  logic [31:0] wb_pc_i;
  logic [2:0]  wb_funct3_i;
  logic [1:0]  wb_byte_off_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic        load_pending_o;
  logic [4:0]  pending_rd_o;
  logic        err_o;

  int n_checks = 0;
  int n_pass   = 0;

  reg_writeback #(.LOAD_TIMEOUT(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wb_valid_i     (wb_valid_i),
    .wb_ready_o     (wb_ready_o),
    .wb_sel_i       (wb_sel_i),
    .wb_rd_i        (wb_rd_i),
    .wb_alu_i       (wb_alu_i),
    .wb_pc_i        (wb_pc_i),
    .wb_funct3_i    (wb_funct3_i),
    .wb_byte_off_i  (wb_byte_off_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .rf_we_o        (rf_we_o),
    .rf_rd_o        (rf_rd_o),
    .rf_wdata_o     (rf_wdata_o),
    .fwd_valid_o    (fwd_valid_o),
    .load_pending_o (load_pending_o),
    .pending_rd_o   (pending_rd_o),
    .err_o          (err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] off);
    wb_valid_i    = 1'b1;
    wb_sel_i      = sel;
    wb_rd_i       = rd;
    wb_alu_i      = alu;
    wb_pc_i       = pc;
    wb_funct3_i   = f3;
    wb_byte_off_i = off;
  endtask

  initial begin
    reset_n       = 1'b0;
    wb_valid_i    = 1'b0;
    wb_sel_i      = 2'b00;
    wb_rd_i       = 5'd0;
    wb_alu_i      = 32'd0;
    wb_pc_i       = 32'd0;
    wb_funct3_i   = 3'd0;
    wb_byte_off_i = 2'd0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'd0;
    tick();
    tick();
    reset_n = 1'b1;

    check("rst_ready", 32'(wb_ready_o), 32'd1);
    check("rst_we", 32'(rf_we_o), 32'd0);
    check("rst_rd", 32'(rf_rd_o), 32'd0);
    check("rst_wdata", rf_wdata_o, 32'd0);
    check("rst_fwd", 32'(fwd_valid_o), 32'd0);
    check("rst_pend", 32'(load_pending_o), 32'd0);
    check("rst_prd", 32'(pending_rd_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // ALU result written one cycle after accept, for exactly one cycle
    issue(2'b01, 5'd5, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0);
    tick();
    wb_valid_i = 1'b0;
    check("alu_we", 32'(rf_we_o), 32'd1);
    check("alu_fwd", 32'(fwd_valid_o), 32'd1);
    check("alu_rd", 32'(rf_rd_o), 32'd5);
    check("alu_wdata", rf_wdata_o, 32'hDEADBEEF);
    tick();
    check("alu_we_off", 32'(rf_we_o), 32'd0);

    // x0 never written; PC+4 wraps
    issue(2'b01, 5'd0, 32'h00000123, 32'h0, 3'd0, 2'd0);
    tick();
    wb_valid_i = 1'b0;
    check("x0_we", 32'(rf_we_o), 32'd0);
    tick();
    issue(2'b11, 5'd7, 32'h0, 32'hFFFFFFFC, 3'd0, 2'd0);
    tick();
    wb_valid_i = 1'b0;
    check("pc4_we", 32'(rf_we_o), 32'd1);
    check("pc4_wdata", rf_wdata_o, 32'h00000000);
    tick();

    // LB offset 2
    issue(2'b10, 5'd9, 32'h0, 32'h0, 3'b000, 2'd2);
    tick();
    wb_valid_i = 1'b0;
    check("lb_pend", 32'(load_pending_o), 32'd1);
    check("lb_ready", 32'(wb_ready_o), 32'd0);
    check("lb_prd", 32'(pending_rd_o), 32'd9);
    check("lb_we_wait", 32'(rf_we_o), 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1280FF34;
    tick();
    dmem_rvalid_i = 1'b0;
    check("lb_we", 32'(rf_we_o), 32'd1);
    check("lb_wdata", rf_wdata_o, 32'hFFFFFF80);
    check("lb_pend_off", 32'(load_pending_o), 32'd0);
    tick();

    // LHU offset 2
    issue(2'b10, 5'd10, 32'h0, 32'h0, 3'b101, 2'd2);
    tick();
    wb_valid_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1280FF34;
    tick();
    dmem_rvalid_i = 1'b0;
    check("lhu_wdata", rf_wdata_o, 32'h00001280);
    check("lhu_rd", 32'(rf_rd_o), 32'd10);
    check("load_err", 32'(err_o), 32'd0);
    tick();

    // Back-to-back ALU stream
    for (int i = 0; i < 4; i++) begin
      issue(2'b01, 5'(i + 1), 32'hA0000000 + 32'(i), 32'h0, 3'd0, 2'd0);
      tick();
      check($sformatf("strm_we%0d", i), 32'(rf_we_o), 32'd1);
      check($sformatf("strm_rd%0d", i), 32'(rf_rd_o), 32'(i + 1));
      check($sformatf("strm_wd%0d", i), rf_wdata_o, 32'hA0000000 + 32'(i));
      check($sformatf("strm_rdy%0d", i), 32'(wb_ready_o), 32'd1);
    end
    wb_valid_i = 1'b0;
    tick();
    check("strm_end", 32'(rf_we_o), 32'd0);

    // Response on the 16th wait cycle beats the timeout
    issue(2'b10, 5'd11, 32'h0, 32'h0, 3'b010, 2'd3);
    tick();
    wb_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("late_pend", 32'(load_pending_o), 32'd1);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFEF00D;
    tick();
    dmem_rvalid_i = 1'b0;
    check("late_we", 32'(rf_we_o), 32'd1);
    check("late_wdata", rf_wdata_o, 32'hCAFEF00D);
    check("late_err", 32'(err_o), 32'd0);
    tick();

    // No response: abort after 16 wait cycles
    issue(2'b10, 5'd12, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    wb_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_pend16", 32'(load_pending_o), 32'd1);
    check("to_err16", 32'(err_o), 32'd0);
    tick();
    check("to_pend", 32'(load_pending_o), 32'd0);
    check("to_we", 32'(rf_we_o), 32'd0);
    check("to_err", 32'(err_o), 32'd1);
    check("to_ready", 32'(wb_ready_o), 32'd1);

    // Reset during WAIT_LOAD, then a stray response
    issue(2'b10, 5'd13, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    wb_valid_i = 1'b0;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rw_err_clr", 32'(err_o), 32'd0);
    check("rw_pend", 32'(load_pending_o), 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h55555555;
    tick();
    dmem_rvalid_i = 1'b0;
    check("rw_we", 32'(rf_we_o), 32'd0);
    check("rw_err", 32'(err_o), 32'd1);

    // Illegal load funct3 writes zero and flags an error
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    issue(2'b10, 5'd14, 32'h0, 32'h0, 3'b011, 2'd0);
    tick();
    wb_valid_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFFFFFF;
    tick();
    dmem_rvalid_i = 1'b0;
    check("bad_we", 32'(rf_we_o), 32'd1);
    check("bad_wdata", rf_wdata_o, 32'h00000000);
    check("bad_err", 32'(err_o), 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
